// File: rtl/mem_port_arbiter.sv
// Shares one word-addressed memory between instruction fetch and data access.
// Data has priority; fetch is protected by a streak limit, accesses by a timeout.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          instr_req,
  input  logic [AW-1:0] instr_addr,
  output logic          instr_ack,
  output logic          instr_err,
  output logic [DW-1:0] instr_rdata,
  input  logic          data_req,
  input  logic          data_we,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_ack,
  output logic          data_err,
  output logic [DW-1:0] data_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          grant_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0] state;
  logic [3:0] streak;
  logic [7:0] tcnt;
  logic       pick_instr;
  logic       tout;

  // Fetch only beats a pending data request once the streak hits the limit
  assign pick_instr = instr_req &&
                      (!data_req || streak == 4'(STARVE_LIMIT));
  assign tout = tcnt == 8'(TIMEOUT - 1);
  assign busy = state != S_IDLE;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      streak      <= '0;
      tcnt        <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      instr_ack   <= 1'b0;
      instr_err   <= 1'b0;
      instr_rdata <= '0;
      data_ack    <= 1'b0;
      data_err    <= 1'b0;
      data_rdata  <= '0;
      grant_data  <= 1'b0;
    end else begin
      instr_ack <= 1'b0;
      instr_err <= 1'b0;
      data_ack  <= 1'b0;
      data_err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!instr_req) streak <= '0;
          if (instr_req || data_req) begin
            state   <= S_ACCESS;
            mem_req <= 1'b1;
            tcnt    <= '0;
            if (pick_instr) begin
              grant_data <= 1'b0;
              mem_we     <= 1'b0;
              mem_addr   <= instr_addr;
              mem_wdata  <= '0;
              streak     <= '0;
            end else begin
              grant_data <= 1'b1;
              mem_we     <= data_we;
              mem_addr   <= data_addr;
              mem_wdata  <= data_wdata;
              if (instr_req && streak != 4'hF)
                streak <= streak + 4'd1;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= S_RESP;
            if (grant_data) begin
              data_ack <= 1'b1;
              if (!mem_we) data_rdata <= mem_rdata;
            end else begin
              instr_ack <= 1'b1;
              if (!mem_we) instr_rdata <= mem_rdata;
            end
          end else if (tout) begin
            mem_req <= 1'b0;
            state   <= S_RESP;
            if (grant_data) begin
              data_ack <= 1'b1;
              data_err <= 1'b1;
            end else begin
              instr_ack <= 1'b1;
              instr_err <= 1'b1;
            end
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random CPU/memory traffic against a transaction-timing model of the arbiter.
// Includes streaming, stuck-memory and asynchronous-reset segments.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;
  localparam int TO  = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          instr_req = 1'b0;
  logic [AW-1:0] instr_addr = '0;
  logic          instr_ack;
  logic          instr_err;
  logic [DW-1:0] instr_rdata;
  logic          data_req = 1'b0;
  logic          data_we = 1'b0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic          data_ack;
  logic          data_err;
  logic [DW-1:0] data_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          busy;
  logic          grant_data;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(LIM), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_ack(instr_ack), .instr_err(instr_err),
    .instr_rdata(instr_rdata),
    .data_req(data_req), .data_we(data_we),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ack(data_ack), .data_err(data_err),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .grant_data(grant_data)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transaction model: grant cycle n0, ack cycle ack_c, k memory wait cycles
  bit            active = 0;
  int            n0, ack_c, k;
  bit            own_d, m_err, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            streak = 0;
  logic [DW-1:0] exp_ird = '0;
  logic [DW-1:0] exp_drd = '0;
  logic [DW-1:0] mem [16];
  int            c = 0;
  bit            rst_pend;
  bit            in_acc, is_ack;

  task automatic chk_zero();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_iack", instr_ack, 0);
    chk("rst_dack", data_ack, 0);
    chk("rst_ierr", instr_err, 0);
    chk("rst_derr", data_err, 0);
    chk("rst_ird", instr_rdata, 0);
    chk("rst_drd", data_rdata, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_grant", grant_data, 0);
  endtask

  initial begin
    int p_i [6] = '{30, 100, 50, 10, 80, 60};
    int p_d [6] = '{30, 100, 90, 10, 80, 60};
    int p_s [6] = '{0, 0, 5, 10, 3, 0};
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    repeat (2) @(posedge clock);
    #1;
    chk_zero();
    reset = 1'b0;
    for (int seg = 0; seg < 6; seg++) begin
      rst_pend = (seg == 3 || seg == 5);
      for (int cyc = 0; cyc < 500; cyc++) begin
        @(posedge clock);
        #1;
        c++;
        if (active && c > ack_c) active = 0;
        in_acc = active && c >= n0 + 1 && c < ack_c;
        is_ack = active && c == ack_c;
        if (is_ack && !m_err) begin
          if (m_we) mem[m_addr[3:0]] = m_wdata;
          else if (own_d) exp_drd = mem[m_addr[3:0]];
          else exp_ird = mem[m_addr[3:0]];
        end
        chk("mem_req", mem_req, in_acc);
        chk("busy", busy, in_acc || is_ack);
        chk("instr_ack", instr_ack, is_ack && !own_d);
        chk("data_ack", data_ack, is_ack && own_d);
        chk("instr_err", instr_err, is_ack && !own_d && m_err);
        chk("data_err", data_err, is_ack && own_d && m_err);
        chk("instr_rdata", instr_rdata, exp_ird);
        chk("data_rdata", data_rdata, exp_drd);
        if (in_acc) begin
          chk("mem_we", mem_we, m_we);
          chk("mem_addr", mem_addr, m_addr);
          chk("mem_wdata", mem_wdata, m_wdata);
        end
        if (in_acc || is_ack) chk("grant_data", grant_data, own_d);

        if (rst_pend && in_acc && c < ack_c - 1) begin
          #2 reset = 1'b1;
          #1 chk_zero();
          #1 reset = 1'b0;
          active = 0;
          streak = 0;
          exp_ird = '0;
          exp_drd = '0;
          rst_pend = 0;
          instr_req = 1'b0;
          data_req = 1'b0;
          mem_ready = 1'b0;
          continue;
        end

        if (is_ack && !own_d) instr_req = 1'b0;
        if (is_ack && own_d) data_req = 1'b0;
        if (!instr_req && $urandom % 100 < p_i[seg]) begin
          instr_req = 1'b1;
          instr_addr = $urandom;
        end
        if (!data_req && $urandom % 100 < p_d[seg]) begin
          data_req = 1'b1;
          data_we = 1'($urandom % 2);
          data_addr = $urandom;
          data_wdata = $urandom;
        end

        if (!active) begin
          if (!instr_req) streak = 0;
          if (instr_req || data_req) begin
            own_d = !(instr_req && (!data_req || streak == LIM));
            if (own_d) begin
              m_we = data_we;
              m_addr = data_addr;
              m_wdata = data_wdata;
              if (instr_req) streak = (streak < 15) ? streak + 1 : 15;
            end else begin
              m_we = 1'b0;
              m_addr = instr_addr;
              m_wdata = '0;
              streak = 0;
            end
            k = ($urandom % 100 < p_s[seg]) ? 1000 : int'($urandom % 4);
            m_err = k > TO - 1;
            ack_c = c + 2 + (m_err ? TO - 1 : k);
            n0 = c;
            active = 1;
          end
        end

        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (active && !m_err && c == n0 + 1 + k) begin
          mem_ready = 1'b1;
          if (!m_we) mem_rdata = mem[m_addr[3:0]];
        end else if (!in_acc && $urandom % 4 == 0) begin
          mem_ready = 1'b1;
        end
      end
      if (rst_pend) begin
        errors++;
        $display("FAIL reset_inject: got none expected one in seg %0d", seg);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
